pipe_regfile: RTL
=================

PIPE_REGFILE -- requirements
Module: pipe_regfile

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data width in bits.
REQ-002 SHALL have parameter NREG, default 32, meaning register count (power of two, >= 2); AW = log2(NREG).
REQ-003 SHALL have parameter BYPASS, default 1, meaning 1 enables write-to-read forwarding in the same cycle.
REQ-004 SHALL have parameter ZERO_REG, default 1, meaning 1 hardwires register 0 to zero (reads 0, writes and issues ignored).
REQ-005 clk  in  1  sole clock; all state changes on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 clr  in  1  synchronous request to re-zero the whole array.
REQ-008 rdy  out  1  array valid and accepting writes/issues.
REQ-009 rs1_addr, rs2_addr  in  AW  read port addresses.
REQ-010 rs1_data, rs2_data  out  XLEN  read port data (combinational).
REQ-011 rs1_busy, rs2_busy  out  1  addressed register has a pending writer.
REQ-012 wr_en  in  1  write strobe.
REQ-013 rd_addr  in  AW  write address.
REQ-014 w_data  in  XLEN  write data.
REQ-015 iss_en  in  1  mark a register pending (instruction issued).
REQ-016 iss_addr  in  AW  register to mark pending.

Function
REQ-017 SHALL implement a two-state FSM: CLEAR (sweep) and IDLE (ready); rdy = 1 only in IDLE.
REQ-018 In CLEAR, SHALL zero exactly one register per cycle at index cnt, cnt counting 0 to NREG-1, then enter IDLE the cycle after cnt = NREG-1 is written (sweep = NREG cycles).
REQ-019 In IDLE, clr = 1 SHALL enter CLEAR with cnt = 0 on the next edge; clr in CLEAR SHALL restart cnt at 0.
REQ-020 Entering CLEAR (reset or clr) SHALL clear all busy bits.
REQ-021 In CLEAR, wr_en and iss_en SHALL be ignored; rs1_data/rs2_data SHALL read 0 and rs1_busy/rs2_busy SHALL read 0.
REQ-022 In IDLE, wr_en = 1 SHALL write w_data to registers[rd_addr] on the rising edge (not the falling edge), except rd_addr = 0 with ZERO_REG = 1.
REQ-023 Reads SHALL return registers[rsN_addr]; address 0 with ZERO_REG = 1 SHALL return 0.
REQ-024 With BYPASS = 1, in IDLE, wr_en = 1 and rd_addr = rsN_addr (non-zero-reg) SHALL drive rsN_data = w_data in the same cycle; with BYPASS = 0 the old value SHALL be read until the edge.
REQ-025 In IDLE, iss_en = 1 SHALL set busy[iss_addr] on the next edge; wr_en = 1 SHALL clear busy[rd_addr] on the next edge.
REQ-026 Simultaneous iss_en and wr_en to the same address SHALL leave busy set (new issue wins).
REQ-027 rsN_busy = busy[rsN_addr], forced 0 when BYPASS = 1 and wr_en = 1 with rd_addr = rsN_addr in IDLE, and forced 0 for register 0 with ZERO_REG = 1.
REQ-028 Both read ports SHALL be independent; equal addresses SHALL return identical data and busy.

Reset
REQ-029 rst_n = 0 SHALL immediately force state = CLEAR, cnt = 0, all busy = 0, rdy = 0, read outputs 0; array contents undefined until swept.
REQ-030 After rst_n rises, SHALL sweep per REQ-018; rdy SHALL rise exactly NREG rising edges later.
REQ-031 rst_n asserted mid-sweep or mid-operation SHALL abandon all activity and restart per REQ-029.

Verification
REQ-032 Reset: rst_n low then high, NREG = 32 -> rdy low for 32 edges, high on 33rd cycle; all 32 registers read 0.
REQ-033 Write/read: wr_en, rd_addr = 5, w_data = 0xDEADBEEF -> same cycle rs1_addr = 5 reads 0xDEADBEEF (BYPASS = 1) or old 0 (BYPASS = 0); next cycle reads 0xDEADBEEF on both ports.
REQ-034 Zero reg: write 0x1234 to addr 0 and iss_en to addr 0 -> rs1_data = 0, rs1_busy = 0.
REQ-035 Scoreboard: iss_en addr 7 -> rs2_busy = 1 next cycle; wr_en addr 7 with iss_en addr 7 same cycle -> busy stays 1; later wr_en addr 7 alone -> busy 0 next cycle.
REQ-036 clr: registers loaded non-zero, clr pulse -> rdy = 0 for NREG cycles, writes ignored, busy all 0, all registers 0 afterwards.
REQ-037 Reset mid-sweep: rst_n low at cnt = 10 -> rdy stays 0, sweep restarts at 0, rdy high NREG edges after rst_n release.

Source files
------------

// File: rtl/pipe_regfile.sv
// pipe_regfile: multi-ported register file with a busy scoreboard.
//
// After reset, or on a clr request, the array is swept to zero one register
// per cycle. rdy stays low for the whole sweep. Once the sweep is done the
// file accepts writes (wr_en) and issue marks (iss_en), and serves two
// independent combinational read ports with optional same-cycle forwarding.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   clr                 synchronous request to re-zero the whole array
//   rdy                 high when the array is valid and accepting writes/issues
//   rs1_addr/rs2_addr   read addresses
//   rs1_data/rs2_data   read data (combinational)
//   rs1_busy/rs2_busy   addressed register has a pending writer
//   wr_en/rd_addr/w_data  write port; a write also clears the register's busy bit
//   iss_en/iss_addr     mark a register as pending
//   dbg_state_o         FSM state (0 = CLEAR sweep, 1 = IDLE)
//   dbg_cnt_o           sweep index
//
// Handshake: there is no back-pressure on individual requests. A write or
// issue is accepted on a rising edge only if rdy is high in that cycle;
// requests presented while rdy is low are dropped.
module pipe_regfile #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  output logic            rdy,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            wr_en,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] w_data,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_addr,
  output logic            dbg_state_o,
  output logic [AW-1:0]   dbg_cnt_o
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic [XLEN-1:0]   regs_q [NREG];

  logic idle;
  logic wr_commit;

  assign idle = (state_q == ST_IDLE);

  // Register 0 is never written when it is hardwired to zero.
  assign wr_commit = idle && wr_en && !((ZERO_REG != 0) && (rd_addr == '0));

  // Next-state logic for the sweep FSM and the busy scoreboard.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      ST_CLEAR: begin
        busy_d = '0;
        if (clr) begin
          cnt_d = '0;
        end else if (cnt_q == AW'(NREG - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      ST_IDLE: begin
        if (clr) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          busy_d  = '0;
        end else begin
          // Issue is applied after the write-clear so a same-address
          // issue+write leaves the register pending.
          if (wr_en)  busy_d[rd_addr]  = 1'b0;
          if (iss_en) busy_d[iss_addr] = 1'b1;
          if (ZERO_REG != 0) busy_d[0] = 1'b0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
        busy_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // The array itself carries no reset; the sweep gives it defined contents.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      regs_q[cnt_q] <= '0;
    end else if (wr_commit) begin
      regs_q[rd_addr] <= w_data;
    end
  end

  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  function automatic logic is_bypass(input logic [AW-1:0] a);
    return (BYPASS != 0) && wr_en && (rd_addr == a);
  endfunction

  // Read ports: zero while sweeping, forwarded write data on an address hit,
  // otherwise the stored value. A forwarded register is no longer pending.
  always_comb begin
    rs1_data = '0;
    rs1_busy = 1'b0;
    if (idle && !is_zero_reg(rs1_addr)) begin
      if (is_bypass(rs1_addr)) begin
        rs1_data = w_data;
      end else begin
        rs1_data = regs_q[rs1_addr];
        rs1_busy = busy_q[rs1_addr];
      end
    end
  end

  always_comb begin
    rs2_data = '0;
    rs2_busy = 1'b0;
    if (idle && !is_zero_reg(rs2_addr)) begin
      if (is_bypass(rs2_addr)) begin
        rs2_data = w_data;
      end else begin
        rs2_data = regs_q[rs2_addr];
        rs2_busy = busy_q[rs2_addr];
      end
    end
  end

  assign rdy         = idle;
  assign dbg_state_o = state_q;
  assign dbg_cnt_o   = cnt_q;

endmodule
